// File: rtl/dm_sba.sv
// System-bus access block of the debug module: SBCS / SBADDRESS0 / SBDATA0 behind a DMI port.
// Define DM_SBA_TIMEOUT_EN to add a bus-response timeout of SBA_TIMEOUT_CYCLES cycles.
module dm_sba #(
  parameter int unsigned SBA_TIMEOUT_CYCLES = 256
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        dmi_req_valid,
  output logic        dmi_req_ready,
  input  logic [40:0] dmi_req,
  output logic        dmi_resp_valid,
  input  logic        dmi_resp_ready,
  output logic [33:0] dmi_resp,
  output logic        sba_req_valid,
  input  logic        sba_req_ready,
  output logic        sba_req_we,
  output logic [31:0] sba_req_addr,
  output logic [31:0] sba_req_wdata,
  output logic [3:0]  sba_req_be,
  input  logic        sba_resp_valid,
  input  logic [31:0] sba_resp_rdata,
  input  logic        sba_resp_err
);

  typedef enum logic [2:0] {
    SBA_IDLE, SBA_READ, SBA_WRITE, SBA_WAIT_READ, SBA_WAIT_WRITE
  } sba_state_e;

  localparam logic [6:0] ADDR_SBCS    = 7'h38;
  localparam logic [6:0] ADDR_SBADDR0 = 7'h39;
  localparam logic [6:0] ADDR_SBDATA0 = 7'h3C;
  localparam logic [1:0] OP_READ      = 2'd1;
  localparam logic [1:0] OP_WRITE     = 2'd2;

  sba_state_e  state_q, state_d;
  logic        rdonaddr_q, rdonaddr_d, autoinc_q, autoinc_d, rdondata_q, rdondata_d;
  logic        busyerr_q, busyerr_d;
  logic [2:0]  access_q, access_d, sberr_q, sberr_d;
  logic [1:0]  size_q, size_d;
  logic [31:0] addr_q, addr_d, data_q, data_d;
  logic        resp_valid_q, resp_valid_d;
  logic [33:0] resp_q, resp_d;
  logic        req_valid_q, req_valid_d, req_we_q, req_we_d;
  logic [31:0] req_addr_q, req_addr_d, req_wdata_q, req_wdata_d;
  logic [3:0]  req_be_q, req_be_d;

`ifdef DM_SBA_TIMEOUT_EN
  localparam int unsigned CW = $clog2(SBA_TIMEOUT_CYCLES) + 1;
  logic [CW-1:0] cnt_q, cnt_d;
`endif

  logic [6:0]  req_a;
  logic [1:0]  req_op;
  logic [31:0] req_wd;
  logic        busy, err_block;
  logic [31:0] sbcs, rdata, start_addr, start_data, rd_shift, rd_aligned;
  logic        start_rd, start_wr, misaligned;

  assign req_a     = dmi_req[40:34];
  assign req_op    = dmi_req[33:32];
  assign req_wd    = dmi_req[31:0];
  assign busy      = (state_q != SBA_IDLE);
  assign err_block = busyerr_q || (sberr_q != 3'd0);
  assign sbcs      = {3'd1, 6'd0, busyerr_q, busy, rdonaddr_q, access_q, autoinc_q,
                      rdondata_q, sberr_q, 7'd32, 5'b00111};

  assign rd_shift   = sba_resp_rdata >> {req_addr_q[1:0], 3'b000};
  assign rd_aligned = (size_q == 2'd0) ? {24'd0, rd_shift[7:0]} :
                      (size_q == 2'd1) ? {16'd0, rd_shift[15:0]} : rd_shift;

  always_comb begin
    state_d     = state_q;
    rdonaddr_d  = rdonaddr_q;
    autoinc_d   = autoinc_q;
    rdondata_d  = rdondata_q;
    busyerr_d   = busyerr_q;
    access_d    = access_q;
    sberr_d     = sberr_q;
    size_d      = size_q;
    addr_d      = addr_q;
    data_d      = data_q;
    resp_valid_d = resp_valid_q && !dmi_resp_ready;
    resp_d      = resp_q;
    req_valid_d = req_valid_q;
    req_we_d    = req_we_q;
    req_addr_d  = req_addr_q;
    req_wdata_d = req_wdata_q;
    req_be_d    = req_be_q;
`ifdef DM_SBA_TIMEOUT_EN
    cnt_d       = cnt_q;
`endif
    rdata       = 32'd0;
    start_rd    = 1'b0;
    start_wr    = 1'b0;
    start_addr  = addr_q;
    start_data  = data_q;

    if (dmi_req_valid && dmi_req_ready) begin
      resp_valid_d = 1'b1;
      if (req_op == OP_WRITE) begin
        case (req_a)
          ADDR_SBCS: begin
            rdonaddr_d = req_wd[20];
            access_d   = req_wd[19:17];
            autoinc_d  = req_wd[16];
            rdondata_d = req_wd[15];
            busyerr_d  = busyerr_q & ~req_wd[22];
            sberr_d    = sberr_q & ~req_wd[14:12];
          end
          ADDR_SBADDR0: begin
            if (busy) busyerr_d = 1'b1;
            else if (!err_block) begin
              addr_d     = req_wd;
              start_addr = req_wd;
              start_rd   = rdonaddr_q;
            end
          end
          ADDR_SBDATA0: begin
            if (busy) busyerr_d = 1'b1;
            else if (!err_block) begin
              data_d     = req_wd;
              start_data = req_wd;
              start_wr   = 1'b1;
            end
          end
          default: ;
        endcase
      end else if (req_op == OP_READ) begin
        case (req_a)
          ADDR_SBCS:    rdata = sbcs;
          ADDR_SBADDR0: rdata = addr_q;
          ADDR_SBDATA0: begin
            rdata = data_q;
            if (busy) busyerr_d = 1'b1;
            else if (rdondata_q && !err_block) start_rd = 1'b1;
          end
          default: ;
        endcase
      end
      resp_d = {rdata, 2'b00};
    end

    misaligned = ((access_q == 3'd1) && start_addr[0]) ||
                 ((access_q == 3'd2) && (start_addr[1:0] != 2'd0));

    if (start_rd || start_wr) begin
      if (access_q > 3'd2) sberr_d = 3'd4;
      else if (misaligned) sberr_d = 3'd3;
      else begin
        state_d     = start_wr ? SBA_WRITE : SBA_READ;
        req_valid_d = 1'b1;
        req_we_d    = start_wr;
        req_addr_d  = start_addr;
        size_d      = access_q[1:0];
        case (access_q[1:0])
          2'd0: begin
            req_be_d    = 4'b0001 << start_addr[1:0];
            req_wdata_d = {4{start_data[7:0]}};
          end
          2'd1: begin
            req_be_d    = 4'b0011 << start_addr[1:0];
            req_wdata_d = {2{start_data[15:0]}};
          end
          default: begin
            req_be_d    = 4'b1111;
            req_wdata_d = start_data;
          end
        endcase
      end
    end

    // Completion updates come last so they win over a same-cycle W1C of sberror.
    case (state_q)
      SBA_READ, SBA_WRITE: begin
        if (sba_req_ready) begin
          req_valid_d = 1'b0;
          state_d     = (state_q == SBA_READ) ? SBA_WAIT_READ : SBA_WAIT_WRITE;
`ifdef DM_SBA_TIMEOUT_EN
          cnt_d       = CW'(SBA_TIMEOUT_CYCLES - 1);
`endif
        end
      end
      SBA_WAIT_READ, SBA_WAIT_WRITE: begin
        if (sba_resp_valid) begin
          state_d = SBA_IDLE;
          if (sba_resp_err) sberr_d = 3'd2;
          else begin
            if (state_q == SBA_WAIT_READ) data_d = rd_aligned;
            if (autoinc_q) addr_d = addr_q + (32'd1 << size_q);
          end
        end
`ifdef DM_SBA_TIMEOUT_EN
        else if (cnt_q == '0) begin
          state_d = SBA_IDLE;
          sberr_d = 3'd1;
        end else begin
          cnt_d = cnt_q - 1'b1;
        end
`endif
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= SBA_IDLE;
      rdonaddr_q   <= 1'b0;
      autoinc_q    <= 1'b0;
      rdondata_q   <= 1'b0;
      busyerr_q    <= 1'b0;
      access_q     <= 3'd2;
      sberr_q      <= 3'd0;
      size_q       <= 2'd0;
      addr_q       <= 32'd0;
      data_q       <= 32'd0;
      resp_valid_q <= 1'b0;
      resp_q       <= 34'd0;
      req_valid_q  <= 1'b0;
      req_we_q     <= 1'b0;
      req_addr_q   <= 32'd0;
      req_wdata_q  <= 32'd0;
      req_be_q     <= 4'd0;
`ifdef DM_SBA_TIMEOUT_EN
      cnt_q        <= '0;
`endif
    end else begin
      state_q      <= state_d;
      rdonaddr_q   <= rdonaddr_d;
      autoinc_q    <= autoinc_d;
      rdondata_q   <= rdondata_d;
      busyerr_q    <= busyerr_d;
      access_q     <= access_d;
      sberr_q      <= sberr_d;
      size_q       <= size_d;
      addr_q       <= addr_d;
      data_q       <= data_d;
      resp_valid_q <= resp_valid_d;
      resp_q       <= resp_d;
      req_valid_q  <= req_valid_d;
      req_we_q     <= req_we_d;
      req_addr_q   <= req_addr_d;
      req_wdata_q  <= req_wdata_d;
      req_be_q     <= req_be_d;
`ifdef DM_SBA_TIMEOUT_EN
      cnt_q        <= cnt_d;
`endif
    end
  end

  assign dmi_req_ready  = !resp_valid_q;
  assign dmi_resp_valid = resp_valid_q;
  assign dmi_resp       = resp_q;
  assign sba_req_valid  = req_valid_q;
  assign sba_req_we     = req_we_q;
  assign sba_req_addr   = req_addr_q;
  assign sba_req_wdata  = req_wdata_q;
  assign sba_req_be     = req_be_q;

endmodule

// File: tb/tb_dm_sba.sv
// Bench for dm_sba: transaction-level register model, directed scenarios, then random DMI/bus traffic.
module tb_dm_sba;
  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        dmi_req_valid = 1'b0, dmi_req_ready;
  logic [40:0] dmi_req = '0;
  logic        dmi_resp_valid, dmi_resp_ready = 1'b0;
  logic [33:0] dmi_resp;
  logic        sba_req_valid, sba_req_ready = 1'b0, sba_req_we;
  logic [31:0] sba_req_addr, sba_req_wdata;
  logic [3:0]  sba_req_be;
  logic        sba_resp_valid = 1'b0, sba_resp_err = 1'b0;
  logic [31:0] sba_resp_rdata = '0;

  dm_sba dut (
    .clk(clk), .rst_n(rst_n),
    .dmi_req_valid(dmi_req_valid), .dmi_req_ready(dmi_req_ready), .dmi_req(dmi_req),
    .dmi_resp_valid(dmi_resp_valid), .dmi_resp_ready(dmi_resp_ready), .dmi_resp(dmi_resp),
    .sba_req_valid(sba_req_valid), .sba_req_ready(sba_req_ready), .sba_req_we(sba_req_we),
    .sba_req_addr(sba_req_addr), .sba_req_wdata(sba_req_wdata), .sba_req_be(sba_req_be),
    .sba_resp_valid(sba_resp_valid), .sba_resp_rdata(sba_resp_rdata), .sba_resp_err(sba_resp_err)
  );

  always #5 clk = ~clk;

  localparam logic [6:0] A_SBCS = 7'h38, A_ADDR = 7'h39, A_DATA = 7'h3C;
  localparam logic [1:0] OP_NOP = 2'd0, OP_R = 2'd1, OP_W = 2'd2;

  int n_cmp = 0, n_fail = 0, bus_cnt = 0;
  logic [31:0] last_resp = '0, last_bus_addr = '0, last_wdata = '0;
  logic [3:0]  last_be = '0;

  typedef struct packed {
    logic        we;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [3:0]  be;
  } bus_t;
  bus_t        exp_bus_q[$];
  logic [31:0] exp_resp_q[$];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // ---------------- register model ----------------
  logic        m_rdonaddr, m_autoinc, m_rdondata, m_busyerr, m_busy, m_pwe;
  logic [2:0]  m_access, m_sberr;
  logic [1:0]  m_psize;
  logic [31:0] m_addr, m_data;

  task automatic m_reset();
    m_rdonaddr = 0; m_autoinc = 0; m_rdondata = 0; m_busyerr = 0; m_busy = 0; m_pwe = 0;
    m_access = 3'd2; m_sberr = 0; m_psize = 0; m_addr = 0; m_data = 0;
  endtask

  function automatic logic [31:0] m_sbcs();
    return {3'd1, 6'd0, m_busyerr, m_busy, m_rdonaddr, m_access, m_autoinc,
            m_rdondata, m_sberr, 7'd32, 5'b00111};
  endfunction

  task automatic m_start(input logic we);
    bus_t b;
    int   bytes;
    if (m_access > 3'd2) m_sberr = 3'd4;
    else begin
      bytes = 1 << m_access;
      if ((m_addr % bytes) != 0) m_sberr = 3'd3;
      else begin
        m_busy = 1; m_pwe = we; m_psize = m_access[1:0];
        b.we = we; b.addr = m_addr;
        case (bytes)
          1: begin b.be = 4'b0001 << m_addr[1:0]; b.wdata = {4{m_data[7:0]}}; end
          2: begin b.be = 4'b0011 << m_addr[1:0]; b.wdata = {2{m_data[15:0]}}; end
          default: begin b.be = 4'b1111; b.wdata = m_data; end
        endcase
        exp_bus_q.push_back(b);
      end
    end
  endtask

  task automatic m_complete(input logic err, input logic [31:0] rd);
    longint bytes;
    m_busy = 0;
    bytes = 64'd1 << m_psize;
    if (err) m_sberr = 3'd2;
    else begin
      if (!m_pwe) m_data = 32'((rd >> (8 * m_addr[1:0])) % (64'd1 << (8 * bytes)));
      if (m_autoinc) m_addr = 32'((64'(m_addr) + bytes) % 64'h1_0000_0000);
    end
  endtask

  task automatic m_dmi(input logic [1:0] op, input logic [6:0] a, input logic [31:0] d);
    logic [31:0] r;
    logic        errs;
    r = 0;
    errs = m_busyerr || (m_sberr != 0);
    if (op == OP_W) begin
      if (a == A_SBCS) begin
        m_rdonaddr = d[20]; m_access = d[19:17]; m_autoinc = d[16]; m_rdondata = d[15];
        if (d[22]) m_busyerr = 0;
        m_sberr = m_sberr & ~d[14:12];
      end else if (a == A_ADDR) begin
        if (m_busy) m_busyerr = 1;
        else if (!errs) begin m_addr = d; if (m_rdonaddr) m_start(0); end
      end else if (a == A_DATA) begin
        if (m_busy) m_busyerr = 1;
        else if (!errs) begin m_data = d; m_start(1); end
      end
    end else if (op == OP_R) begin
      if (a == A_SBCS) r = m_sbcs();
      else if (a == A_ADDR) r = m_addr;
      else if (a == A_DATA) begin
        r = m_data;
        if (m_busy) m_busyerr = 1;
        else if (m_rdondata && !errs) m_start(0);
      end
    end
    exp_resp_q.push_back(r);
  endtask

  // ---------------- compare process ----------------
  always @(negedge clk) begin : cmp
    bus_t e;
    logic [31:0] er;
    if (rst_n) begin
      if (!m_busy) chk("sba_req_valid_idle", {31'd0, sba_req_valid}, 32'd0);
      if (dmi_resp_valid && dmi_resp_ready) begin
        if (exp_resp_q.size() == 0) chk("dmi_resp_unexpected", 32'd1, 32'd0);
        else begin
          er = exp_resp_q.pop_front();
          chk("dmi_resp_data", dmi_resp[33:2], er);
          chk("dmi_resp_code", {30'd0, dmi_resp[1:0]}, 32'd0);
        end
        last_resp = dmi_resp[33:2];
      end
      if (sba_req_valid && sba_req_ready) begin
        bus_cnt++;
        last_bus_addr = sba_req_addr; last_be = sba_req_be; last_wdata = sba_req_wdata;
        if (exp_bus_q.size() == 0) chk("sba_req_unexpected", 32'd1, 32'd0);
        else begin
          e = exp_bus_q.pop_front();
          chk("sba_req_we", {31'd0, sba_req_we}, {31'd0, e.we});
          chk("sba_req_addr", sba_req_addr, e.addr);
          chk("sba_req_be", {28'd0, sba_req_be}, {28'd0, e.be});
          if (e.we) chk("sba_req_wdata", sba_req_wdata, e.wdata);
        end
      end
    end
  end

  // ---------------- drivers ----------------
  task automatic dmi(input logic [1:0] op, input logic [6:0] a, input logic [31:0] d);
    int n;
    m_dmi(op, a, d);
    @(posedge clk); #1;
    dmi_req_valid = 1; dmi_req = {a, op, d};
    n = 0;
    while (!dmi_req_ready && n < 20) begin @(posedge clk); #1; n++; end
    chk("dmi_req_ready", {31'd0, dmi_req_ready}, 32'd1);
    @(posedge clk); #1;
    dmi_req_valid = 0; dmi_req = '0;
    n = 0;
    while (!dmi_resp_valid && n < 20) begin @(posedge clk); #1; n++; end
    chk("dmi_resp_seen", {31'd0, dmi_resp_valid}, 32'd1);
    if (!dmi_resp_valid) begin
      if (exp_resp_q.size() > 0) void'(exp_resp_q.pop_front());
      return;
    end
    repeat ($urandom % 3) begin @(posedge clk); #1; end
    dmi_resp_ready = 1;
    @(posedge clk); #1;
    dmi_resp_ready = 0;
  endtask

  task automatic bus_accept();
    int n;
    n = 0;
    while (!sba_req_valid && n < 50) begin @(posedge clk); #1; n++; end
    chk("sba_req_seen", {31'd0, sba_req_valid}, 32'd1);
    if (!sba_req_valid) return;
    repeat ($urandom % 4) begin @(posedge clk); #1; end
    sba_req_ready = 1;
    @(posedge clk); #1;
    sba_req_ready = 0;
  endtask

  task automatic bus_respond(input logic [31:0] rd, input logic err);
    repeat ($urandom % 4) begin @(posedge clk); #1; end
    sba_resp_valid = 1; sba_resp_rdata = rd; sba_resp_err = err;
    @(posedge clk); #1;
    sba_resp_valid = 0; sba_resp_err = 0; sba_resp_rdata = $urandom;
    m_complete(err, rd);
  endtask

  task automatic busy_op();
    case ($urandom % 5)
      0: dmi(OP_W, A_ADDR, $urandom);
      1: dmi(OP_W, A_DATA, $urandom);
      2: dmi(OP_R, A_DATA, 0);
      3: dmi(OP_R, A_SBCS, 0);
      default: dmi(OP_R, 7'h10, 0);
    endcase
  endtask

  function automatic logic [31:0] rand_addr();
    case ($urandom % 4)
      0: return $urandom;
      1: return $urandom & ~32'h3;
      2: return 32'hFFFF_FFFC | ($urandom % 4);
      default: return ($urandom & 32'hFFF0) | ($urandom % 4);
    endcase
  endfunction

  initial begin : watchdog
    #900000;
    $display("FAIL watchdog: got timeout expected completion");
    n_fail++;
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $fatal(1);
  end

  initial begin : stim
    logic [31:0] d;
    logic [6:0]  oa;
    int          c;
    m_reset();
    #12;
    chk("rst_dmi_req_ready", {31'd0, dmi_req_ready}, 32'd1);
    chk("rst_dmi_resp_valid", {31'd0, dmi_resp_valid}, 32'd0);
    chk("rst_dmi_resp", dmi_resp[33:2], 32'd0);
    chk("rst_sba_req_valid", {31'd0, sba_req_valid}, 32'd0);
    chk("rst_sba_req_addr", sba_req_addr, 32'd0);
    chk("rst_sba_req_wdata", sba_req_wdata, 32'd0);
    chk("rst_sba_req_be_we", {27'd0, sba_req_we, sba_req_be}, 32'd0);
    @(posedge clk); #1; rst_n = 1;

    dmi(OP_R, A_SBCS, 0);
    chk("sbcs_reset_value", last_resp, 32'h2004_0407);

    // single word write
    dmi(OP_W, A_SBCS, 32'd2 << 17);
    dmi(OP_W, A_ADDR, 32'h1000);
    dmi(OP_W, A_DATA, 32'hDEAD_BEEF);
    bus_accept(); bus_respond(32'h0, 0);
    chk("wr32_addr", last_bus_addr, 32'h1000);
    chk("wr32_be", {28'd0, last_be}, 32'hF);
    chk("wr32_wdata", last_wdata, 32'hDEAD_BEEF);
    dmi(OP_R, A_SBCS, 0);
    chk("wr32_sbbusy_after", {31'd0, last_resp[21]}, 32'd0);

    // byte read on address write, top lane
    dmi(OP_W, A_SBCS, 32'd1 << 20);
    dmi(OP_W, A_ADDR, 32'h2003);
    bus_accept(); bus_respond(32'hAB00_0000, 0);
    chk("rd8_be", {28'd0, last_be}, 32'h8);
    dmi(OP_R, A_DATA, 0);
    chk("rd8_data", last_resp, 32'h0000_00AB);

    // autoincrementing read-on-data stream
    dmi(OP_W, A_SBCS, (32'd1 << 20) | (32'd2 << 17) | (32'd1 << 16) | (32'd1 << 15));
    dmi(OP_W, A_ADDR, 32'h3000);
    bus_accept(); bus_respond($urandom, 0);
    chk("stream_first_addr", last_bus_addr, 32'h3000);
    for (int i = 1; i <= 3; i++) begin
      dmi(OP_R, A_DATA, 0);
      bus_accept(); bus_respond($urandom, 0);
      chk("stream_addr", last_bus_addr, 32'h3000 + 32'(4 * i));
    end

    // busy error while bus stalls
    dmi(OP_W, A_SBCS, 32'd2 << 17);
    dmi(OP_W, A_ADDR, 32'h5000);
    c = bus_cnt;
    dmi(OP_W, A_DATA, 32'h1111_1111);
    dmi(OP_W, A_DATA, 32'h2222_2222);
    dmi(OP_R, A_SBCS, 0);
    chk("busyerr_set", {30'd0, last_resp[22:21]}, 32'd3);
    bus_accept(); bus_respond(0, 0);
    repeat (5) @(posedge clk);
    #1;
    chk("busyerr_single_write", 32'(bus_cnt - c), 32'd1);
    chk("busyerr_wdata", last_wdata, 32'h1111_1111);
    dmi(OP_W, A_SBCS, (32'd1 << 22) | (32'd2 << 17));
    dmi(OP_R, A_SBCS, 0);
    chk("busyerr_cleared", {31'd0, last_resp[22]}, 32'd0);

    // alignment error then bus error
    dmi(OP_W, A_SBCS, (32'd1 << 20) | (32'd1 << 17));
    dmi(OP_W, A_ADDR, 32'h4001);
    repeat (3) @(posedge clk);
    #1;
    chk("align_no_req", {31'd0, sba_req_valid}, 32'd0);
    dmi(OP_R, A_SBCS, 0);
    chk("align_sberror", {29'd0, last_resp[14:12]}, 32'd3);
    dmi(OP_W, A_SBCS, (32'd1 << 20) | (32'd1 << 17) | (32'd7 << 12));
    dmi(OP_W, A_ADDR, 32'h4002);
    bus_accept(); bus_respond($urandom, 1);
    dmi(OP_R, A_SBCS, 0);
    chk("buserr_sberror", {29'd0, last_resp[14:12]}, 32'd2);
    dmi(OP_W, A_SBCS, (32'd2 << 17) | (32'd7 << 12));

    // no response: timeout or persistent wait
    dmi(OP_W, A_ADDR, 32'h6000);
    dmi(OP_W, A_DATA, 32'h1234_5678);
    bus_accept();
`ifdef DM_SBA_TIMEOUT_EN
    repeat (300) @(posedge clk);
    #1;
    m_busy = 0; m_sberr = 3'd1;
    dmi(OP_R, A_SBCS, 0);
    chk("timeout_sberror", {29'd0, last_resp[14:12]}, 32'd1);
    chk("timeout_idle", {31'd0, last_resp[21]}, 32'd0);
    dmi(OP_W, A_SBCS, (32'd2 << 17) | (32'd7 << 12));
`else
    repeat (1000) @(posedge clk);
    #1;
    dmi(OP_R, A_SBCS, 0);
    chk("no_timeout_busy", {31'd0, last_resp[21]}, 32'd1);
    bus_respond(0, 0);
`endif

    // reset in the middle of a read
    dmi(OP_W, A_SBCS, (32'd1 << 20) | (32'd2 << 17));
    dmi(OP_W, A_ADDR, 32'h7000);
    bus_accept();
    rst_n = 0;
    #1;
    chk("midrst_req_valid", {31'd0, sba_req_valid}, 32'd0);
    chk("midrst_resp_valid", {31'd0, dmi_resp_valid}, 32'd0);
    chk("midrst_req_addr", sba_req_addr, 32'd0);
    @(posedge clk); @(posedge clk); #1;
    rst_n = 1;
    m_reset(); exp_bus_q.delete(); exp_resp_q.delete();
    @(posedge clk); #1;
    sba_resp_valid = 1; sba_resp_rdata = 32'hFFFF_FFFF;
    @(posedge clk); #1;
    sba_resp_valid = 0;
    dmi(OP_R, A_SBCS, 0);
    chk("midrst_sbcs", last_resp, 32'h2004_0407);
    dmi(OP_R, A_DATA, 0);
    chk("midrst_data", last_resp, 32'd0);

    // random traffic
    for (int it = 0; it < 400; it++) begin
      c = $urandom % 16;
      if (c < 4) begin
        d = $urandom;
        d[19:17] = ($urandom % 10 == 0) ? 3'(3 + $urandom % 5) : 3'($urandom % 3);
        if ($urandom % 4 != 0) begin d[22] = 1; d[14:12] = 3'd7; end
        dmi(OP_W, A_SBCS, d);
      end else if (c < 7) dmi(OP_W, A_ADDR, rand_addr());
      else if (c < 9) dmi(OP_W, A_DATA, $urandom);
      else if (c < 12) dmi(OP_R, A_DATA, 0);
      else if (c == 12) dmi(OP_R, A_SBCS, 0);
      else if (c == 13) dmi(OP_R, A_ADDR, 0);
      else if (c == 14) begin
        oa = 7'($urandom % 56);
        dmi(($urandom % 2) ? OP_W : OP_R, oa, $urandom);
      end else dmi(OP_NOP, 7'($urandom), $urandom);

      if (m_busy) begin
        repeat ($urandom % 3) busy_op();
        bus_accept();
        if ($urandom % 4 == 0) busy_op();
        bus_respond($urandom, ($urandom % 8) == 0);
      end else if ($urandom % 8 == 0) begin
        sba_resp_valid = 1; sba_resp_err = $urandom; sba_resp_rdata = $urandom;
        @(posedge clk); #1;
        sba_resp_valid = 0; sba_resp_err = 0;
      end
    end

    repeat (5) @(posedge clk);
    #1;
    chk("resp_queue_drained", exp_resp_q.size(), 32'd0);
    chk("bus_queue_drained", exp_bus_q.size(), 32'd0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end
endmodule
